// File: rtl/pc_gen.sv
// Fetch program-counter generator: next-PC selection (trap, return, branch,
// +2/+4 increment), a per-stage PC history, EPC capture and misaligned-target flag.
module pc_gen #(
  parameter int              XLEN       = 32,
  parameter int              HIST_DEPTH = 2,
  parameter logic [XLEN-1:0] RESET_VEC  = {XLEN{1'b0}},
  parameter logic [31:0]     TRAP_VEC   = 32'h0000_0100,
  parameter int              C_EXT      = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       stall_i,
  input  logic                       incr_pc_i,
  input  logic                       incr_half_i,
  input  logic                       branch_taken_i,
  input  logic [XLEN-1:0]            target_i,
  input  logic                       trap_i,
  input  logic                       mret_i,
  output logic [XLEN-1:0]            pc_o,
  output logic [HIST_DEPTH*XLEN-1:0] pc_hist_o,
  output logic [XLEN-1:0]            epc_o,
  output logic                       misalign_o
);

  localparam logic [XLEN-1:0] TRAP_PC    = XLEN'(TRAP_VEC);
  localparam logic [XLEN-1:0] ALIGN_MASK = (C_EXT != 0) ? XLEN'(2'b01) : XLEN'(2'b11);
  localparam logic [XLEN-1:0] STEP_HALF  = XLEN'(3'd2);
  localparam logic [XLEN-1:0] STEP_WORD  = XLEN'(3'd4);

  function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] t);
    return t & ~ALIGN_MASK;
  endfunction

  function automatic logic is_misaligned(input logic [XLEN-1:0] t);
    return |(t & ALIGN_MASK);
  endfunction

  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] hist_r [HIST_DEPTH];
  logic [XLEN-1:0] epc_r;
  logic            misalign_r;

  logic [XLEN-1:0] step_s;
  logic [XLEN-1:0] next_pc_s;
  logic [XLEN-1:0] next_epc_s;
  logic            next_misalign_s;
  logic            advance_s;

  // Increment size: half-word steps only exist when compressed support is built in.
  always_comb begin
    step_s = STEP_WORD;
    if (incr_half_i && (C_EXT != 0)) begin
      step_s = STEP_HALF;
    end else begin
      step_s = STEP_WORD;
    end
  end

  // Next-state selection; a trap wins even over a stall, and advances the history.
  always_comb begin
    next_pc_s       = pc_r;
    next_epc_s      = epc_r;
    next_misalign_s = misalign_r;
    advance_s       = 1'b0;
    if (trap_i) begin
      next_pc_s       = TRAP_PC;
      next_epc_s      = hist_r[HIST_DEPTH-1];
      next_misalign_s = 1'b0;
      advance_s       = 1'b1;
    end else if (stall_i) begin
      next_pc_s       = pc_r;
      next_epc_s      = epc_r;
      next_misalign_s = misalign_r;
      advance_s       = 1'b0;
    end else begin
      advance_s       = 1'b1;
      next_misalign_s = 1'b0;
      if (mret_i) begin
        next_pc_s = epc_r;
      end else if (branch_taken_i) begin
        next_pc_s       = align_target(target_i);
        next_misalign_s = is_misaligned(target_i);
      end else if (incr_pc_i) begin
        next_pc_s = pc_r + step_s;
      end else begin
        next_pc_s = pc_r;
      end
    end
  end

  // State registers; history shifts by one entry on every advancing cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_r       <= RESET_VEC;
      epc_r      <= {XLEN{1'b0}};
      misalign_r <= 1'b0;
      for (int k = 0; k < HIST_DEPTH; k++) begin
        hist_r[k] <= RESET_VEC;
      end
    end else begin
      pc_r       <= next_pc_s;
      epc_r      <= next_epc_s;
      misalign_r <= next_misalign_s;
      if (advance_s) begin
        hist_r[0] <= pc_r;
        for (int k = 1; k < HIST_DEPTH; k++) begin
          hist_r[k] <= hist_r[k-1];
        end
      end
    end
  end

  assign pc_o       = pc_r;
  assign epc_o      = epc_r;
  assign misalign_o = misalign_r;

  for (genvar g = 0; g < HIST_DEPTH; g++) begin : g_hist
    assign pc_hist_o[g*XLEN +: XLEN] = hist_r[g];
  end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: two instances (compressed, depth 2 / word-only, depth 3)
// driven in parallel and compared each cycle against a trace-based model.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, incr, half, br, trap, mret;
  logic [31:0] tgt;

  logic [31:0] pc1, epc1, pc0, epc0;
  logic [63:0] hist1;
  logic [95:0] hist0;
  logic        mis1, mis0;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(32), .HIST_DEPTH(2), .RESET_VEC(32'h0), .TRAP_VEC(32'h100), .C_EXT(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .incr_pc_i(incr), .incr_half_i(half),
    .branch_taken_i(br), .target_i(tgt), .trap_i(trap), .mret_i(mret),
    .pc_o(pc1), .pc_hist_o(hist1), .epc_o(epc1), .misalign_o(mis1));

  pc_gen #(.XLEN(32), .HIST_DEPTH(3), .RESET_VEC(32'h0), .TRAP_VEC(32'h100), .C_EXT(0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .incr_pc_i(incr), .incr_half_i(half),
    .branch_taken_i(br), .target_i(tgt), .trap_i(trap), .mret_i(mret),
    .pc_o(pc0), .pc_hist_o(hist0), .epc_o(epc0), .misalign_o(mis0));

  // Model: the history is simply the list of PCs seen on every advancing cycle.
  typedef struct { logic [31:0] p0; logic [31:0] p1; } pair_t;
  pair_t       trace [$];
  logic [31:0] m_pc0, m_pc1, m_epc0, m_epc1;
  logic        m_mis0, m_mis1;
  bit          chk_en = 1'b0;
  int          n_chk  = 0;
  int          n_pass = 0;

  function automatic logic [31:0] m_hist(input int inst, input int k);
    pair_t e;
    e = trace[trace.size() - 1 - k];
    return (inst == 1) ? e.p1 : e.p0;
  endfunction

  task automatic model_reset();
    pair_t z;
    z.p0 = 32'h0;
    z.p1 = 32'h0;
    m_pc0 = 32'h0; m_pc1 = 32'h0; m_epc0 = 32'h0; m_epc1 = 32'h0;
    m_mis0 = 1'b0; m_mis1 = 1'b0;
    trace.delete();
    for (int i = 0; i < 8; i++) trace.push_back(z);
  endtask

  task automatic model_step();
    pair_t cur;
    cur.p0 = m_pc0;
    cur.p1 = m_pc1;
    if (trap) begin
      m_epc0 = m_hist(0, 2);
      m_epc1 = m_hist(1, 1);
      trace.push_back(cur);
      m_pc0 = 32'h100; m_pc1 = 32'h100;
      m_mis0 = 1'b0; m_mis1 = 1'b0;
    end else if (!stall) begin
      trace.push_back(cur);
      m_mis0 = 1'b0; m_mis1 = 1'b0;
      if (mret) begin
        m_pc0 = m_epc0; m_pc1 = m_epc1;
      end else if (br) begin
        m_pc1  = tgt - (tgt % 32'd2);
        m_mis1 = (tgt % 32'd2) != 32'd0;
        m_pc0  = tgt - (tgt % 32'd4);
        m_mis0 = (tgt % 32'd4) != 32'd0;
      end else if (incr) begin
        m_pc1 = m_pc1 + (half ? 32'd2 : 32'd4);
        m_pc0 = m_pc0 + 32'd4;
      end
    end
    if (trace.size() > 32) void'(trace.pop_front());
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic set_in(input logic s, input logic i, input logic h, input logic b,
                        input logic [31:0] t, input logic tr, input logic mr);
    stall = s; incr = i; half = h; br = b; tgt = t; trap = tr; mret = mr;
  endtask

  task automatic cyc(input logic s, input logic i, input logic h, input logic b,
                     input logic [31:0] t, input logic tr, input logic mr);
    set_in(s, i, h, b, t, tr, mr);
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pc1"}, pc1, 32'h0);
    check({tag, "_pc0"}, pc0, 32'h0);
    check({tag, "_hist1"}, hist1[63:32] | hist1[31:0], 32'h0);
    check({tag, "_hist0"}, hist0[95:64] | hist0[63:32] | hist0[31:0], 32'h0);
    check({tag, "_epc1"}, epc1, 32'h0);
    check({tag, "_epc0"}, epc0, 32'h0);
    check({tag, "_mis"}, {30'h0, mis1, mis0}, 32'h0);
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_pc1", pc1, m_pc1);
      check("cyc_pc0", pc0, m_pc0);
      check("cyc_epc1", epc1, m_epc1);
      check("cyc_epc0", epc0, m_epc0);
      check("cyc_mis1", {31'h0, mis1}, {31'h0, m_mis1});
      check("cyc_mis0", {31'h0, mis0}, {31'h0, m_mis0});
      for (int k = 0; k < 2; k++)
        check($sformatf("cyc_hist1_%0d", k), hist1[k*32 +: 32], m_hist(1, k));
      for (int k = 0; k < 3; k++)
        check($sformatf("cyc_hist0_%0d", k), hist0[k*32 +: 32], m_hist(0, k));
    end
  end

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    model_reset();
    #3;
    check_reset_vals("rst");
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // increment 4, 8, 0xC
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("inc_pc_a", pc1, 32'h4);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("inc_pc_b", pc1, 32'h8);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("inc_pc_c", pc1, 32'hC);
    check("inc_hist0", hist1[31:0], 32'h8);
    check("inc_hist1", hist1[63:32], 32'h4);

    // stall holds everything, then resumes
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("stall_pc", pc1, 32'hC);
    check("stall_hist0", hist1[31:0], 32'h8);
    check("stall_hist1", hist1[63:32], 32'h4);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("unstall_pc", pc1, 32'h10);

    // misaligned branch
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h103, 1'b0, 1'b0);
    check("br_pc0", pc0, 32'h100);
    check("br_mis0", {31'h0, mis0}, 32'h1);
    check("br_pc1", pc1, 32'h102);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("br_inc_pc0", pc0, 32'h104);
    check("br_inc_mis0", {31'h0, mis0}, 32'h0);

    // compressed increment and half-word target
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    check("half_pc1", pc1, 32'h22);
    check("half_pc0", pc0, 32'h24);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h31, 1'b0, 1'b0);
    check("c_br_pc1", pc1, 32'h30);
    check("c_br_mis1", {31'h0, mis1}, 32'h1);

    // trap under stall, then return
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h38, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("pre_trap_pc", pc1, 32'h40);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("trap_pc1", pc1, 32'h100);
    check("trap_epc1", epc1, 32'h38);
    check("trap_epc0", epc0, 32'h30);
    check("trap_hist0", hist1[31:0], 32'h40);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("mret_pc1", pc1, 32'h38);
    check("mret_pc0", pc0, 32'h30);

    // wrap-around
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("wrap_pc1", pc1, 32'h0);
    check("wrap_pc0", pc0, 32'h0);

    // reset asserted while a branch is pending
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h203, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_vals("midrst");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h203, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h203, 1'b0, 1'b0);
    check_reset_vals("rsthold");
    rst_n = 1'b1;

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom % 5) == 0, ($urandom % 10) < 7, $urandom % 2, ($urandom % 4) == 0,
          (($urandom % 8) == 0) ? 32'hFFFF_FFF0 | ($urandom % 16) : $urandom,
          ($urandom % 20) == 0, ($urandom % 10) == 0);
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the tamarisc fetch front end. It holds the fetch PC and a `HIST_DEPTH`-deep shift history of PCs, one entry per pipeline stage, so downstream stages can recover the PC of the instruction they hold. Beyond plain increment and branch redirect, it adds selectable +2/+4 increment for compressed instructions, trap entry with EPC capture, trap return, and misaligned-target detection.

## Interface
Parameters:
- `XLEN`, 32: PC width; legal values 32 or 64.
- `HIST_DEPTH`, 2: number of delayed PC stages; legal range 1..8.
- `RESET_VEC`, 0: PC value loaded at reset.
- `TRAP_VEC`, 32'h100: PC loaded on trap entry; zero-extended to `XLEN`.
- `C_EXT`, 1: 1 enables 16-bit instruction alignment and +2 increments.

Ports (clock and reset first):
- `clk_i`  in  1  clock.
- `rst_n_i`  in  1  reset; asynchronous, active-low.
- `stall_i`  in  1  hold the PC and the whole history.
- `incr_pc_i`  in  1  advance the PC.
- `incr_half_i`  in  1  when high and `C_EXT`=1, the increment is +2; otherwise it is +4.
- `branch_taken_i`  in  1  redirect to `target_i`.
- `target_i`  in  XLEN  branch/jump target from the ALU.
- `trap_i`  in  1  enter trap.
- `mret_i`  in  1  return to the saved EPC.
- `pc_o`  out  XLEN  current fetch PC.
- `pc_hist_o`  out  HIST_DEPTH*XLEN  history; entry k (bits `[k*XLEN +: XLEN]`) is the PC delayed by k+1 cycles.
- `epc_o`  out  XLEN  saved exception PC.
- `misalign_o`  out  1  registered flag: the last taken branch target was misaligned.

## Operation
- Next-PC selection, highest priority first:
  1. `trap_i`: next PC = `TRAP_VEC`. Also `epc_q` <= oldest history entry, `hist[HIST_DEPTH-1]`. `trap_i` overrides `stall_i`.
  2. `stall_i`: PC, history and `misalign_o` hold.
  3. `mret_i`: next PC = `epc_q`.
  4. `branch_taken_i`: next PC = `target_i`, aligned as below.
  5. `incr_pc_i`: next PC = PC + (`incr_half_i` && `C_EXT` ? 2 : 4).
  6. Otherwise the PC holds.
- Target alignment:
  - `C_EXT`=1: bit 0 is forced to 0.
  - `C_EXT`=0: bits [1:0] are forced to 0.
  - `misalign_o` <= 1 when a branch is taken with a bit cleared that was set (`C_EXT`=1: bit 0; `C_EXT`=0: bits [1:0]). Any other non-stalled, non-trap update clears it. A trap clears it.
- History:
  - On any non-stalled cycle, including a trap: `hist[0]` <= PC and `hist[k]` <= `hist[k-1]`.
  - No flush on redirect; downstream kill logic owns squashing.
- Arithmetic: the increment is modulo 2^XLEN, so 0xFFFF_FFFC + 4 = 0 when `XLEN`=32. No carry output.
- `epc_q` changes only on `trap_i`. A simultaneous `trap_i` and `mret_i` takes the trap and captures the pre-trap history entry.

## Timing
- Reset, asynchronous:
  - `pc_o` = `RESET_VEC`.
  - All history entries = `RESET_VEC`.
  - `epc_o` = 0.
  - `misalign_o` = 0.
  - Release is synchronous to the next `clk_i` rising edge; the first update occurs on the first edge with `rst_n_i`=1.
- All outputs are registered with no combinational input-to-output path. Redirect latency is 1 cycle: the target appears on `pc_o` the edge after the request.
- History entry k shows the PC value from k+1 non-stalled cycles earlier; stalled cycles do not count.
- Reset asserted mid-operation overrides everything immediately. Requests pending in that cycle are lost.

## Test plan
- Reset/increment (`RESET_VEC`=0, `HIST_DEPTH`=2): hold `incr_pc_i`=1 for 3 cycles -> `pc_o` 4, 8, 0xC. `pc_hist_o` entry0 = 8 and entry1 = 4 when `pc_o`=0xC.
- Stall (`pc_o`=8): `stall_i`=1 with `incr_pc_i`=1 for 2 cycles -> `pc_o`, history and `misalign_o` unchanged. The cycle after release, `pc_o`=0xC.
- Branch and misalignment (`C_EXT`=0): `branch_taken_i`, `target_i`=0x103 -> `pc_o`=0x100 and `misalign_o`=1. Next increment -> `pc_o`=0x104 and `misalign_o`=0.
- Compressed increment (`C_EXT`=1, `pc_o`=0x20): `incr_half_i`=1 -> 0x22. Branch to 0x31 -> 0x30 with `misalign_o`=1.
- Trap/return (`pc_o`=0x40, `hist[1]`=0x38): `trap_i`=1 during `stall_i`=1 -> `pc_o`=0x100 and `epc_o`=0x38. Then `mret_i` -> `pc_o`=0x38.
- Wrap and reset (`XLEN`=32): increment from 0xFFFF_FFFC -> 0. Asserting `rst_n_i`=0 mid-branch -> all outputs return to reset values immediately.
